// File: rtl/uart_16550_rx_fifo.sv
// Receive FIFO for the fabric 16550: FWFT byte store with per-character error flags,
// LSR/IIR status terms. Define UART_RX_FIFO_TIMEOUT_EN to build the character-timeout counter.
module uart_16550_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic                  Rx_FIFO_Flush_i,
    input  logic                  Rx_FIFO_Push_i,
    input  logic [7:0]            Rx_DAT_i,
    input  logic                  Rx_PE_i,
    input  logic                  Rx_FE_i,
    input  logic                  Rx_BI_i,
    input  logic                  Rx_FIFO_Pop_i,
    output logic [7:0]            Rx_FIFO_DAT_o,
    output logic                  Rx_FIFO_PE_o,
    output logic                  Rx_FIFO_FE_o,
    output logic                  Rx_FIFO_BI_o,
    output logic                  Rx_FIFO_Empty_o,
    output logic                  Rx_FIFO_Full_o,
    output logic [DEPTH_LOG2:0]   Rx_FIFO_Level_o,
    output logic                  Rx_FIFO_Err_o,
    output logic                  Rx_Overrun_o,
    input  logic                  Rx_Overrun_Clr_i,
    input  logic [1:0]            Rx_Trig_Lvl_i,
    output logic                  Rx_Trig_o,
    input  logic                  Rx_Char_Tick_i,
    output logic                  Rx_Timeout_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic [10:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [LW-1:0]         r_err_cnt;
    logic                  r_overrun;

    logic [10:0] w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_pop_ok;
    logic        w_push_ok;
    logic        w_drop;
    logic        w_push_err;
    logic        w_head_err;
    logic [31:0] w_thr_raw;
    logic [31:0] w_thr;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_pop_ok   = Rx_FIFO_Pop_i & ~w_empty & ~Rx_FIFO_Flush_i;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign w_push_ok  = Rx_FIFO_Push_i & (~w_full | w_pop_ok) & ~Rx_FIFO_Flush_i;
    assign w_drop     = Rx_FIFO_Push_i & ~w_push_ok & ~Rx_FIFO_Flush_i;
    assign w_push_err = Rx_PE_i | Rx_FE_i | Rx_BI_i;
    assign w_head_err = |w_head[10:8];

    always_ff @(posedge WBs_CLK_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {Rx_BI_i, Rx_FE_i, Rx_PE_i, Rx_DAT_i};
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i || Rx_FIFO_Flush_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            case ({w_push_ok & w_push_err, w_pop_ok & w_head_err})
                2'b10:   r_err_cnt <= r_err_cnt + LW'(1);
                2'b01:   r_err_cnt <= r_err_cnt - LW'(1);
                default: r_err_cnt <= r_err_cnt;
            endcase
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (Rx_Overrun_Clr_i) begin
            r_overrun <= 1'b0;
        end
    end

    always_comb begin
        w_thr_raw = 32'd1;
        case (Rx_Trig_Lvl_i)
            2'b00: w_thr_raw = 32'd1;
            2'b01: w_thr_raw = 32'd4;
            2'b10: w_thr_raw = 32'd8;
            2'b11: w_thr_raw = 32'd14;
            default: w_thr_raw = 32'd1;
        endcase
        w_thr = (w_thr_raw > DEPTH) ? DEPTH : w_thr_raw;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [2:0] r_tmo_cnt;

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i || Rx_FIFO_Flush_i || Rx_FIFO_Push_i || Rx_FIFO_Pop_i || w_empty) begin
            r_tmo_cnt <= '0;
        end else if (Rx_Char_Tick_i && (r_tmo_cnt != 3'd4)) begin
            r_tmo_cnt <= r_tmo_cnt + 3'd1;
        end
    end

    assign Rx_Timeout_o = (r_tmo_cnt == 3'd4);
`else
    logic w_unused_tick;
    assign w_unused_tick = Rx_Char_Tick_i;
    assign Rx_Timeout_o  = 1'b0;
`endif

    assign Rx_FIFO_DAT_o   = w_empty ? '0 : w_head[7:0];
    assign Rx_FIFO_PE_o    = ~w_empty & w_head[8];
    assign Rx_FIFO_FE_o    = ~w_empty & w_head[9];
    assign Rx_FIFO_BI_o    = ~w_empty & w_head[10];
    assign Rx_FIFO_Empty_o = w_empty;
    assign Rx_FIFO_Full_o  = w_full;
    assign Rx_FIFO_Level_o = r_level;
    assign Rx_FIFO_Err_o   = (r_err_cnt != '0);
    assign Rx_Overrun_o    = r_overrun;
    assign Rx_Trig_o       = (32'(r_level) >= w_thr);

endmodule
